// File: rtl/pipe_scroll_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_scroll_ctrl
//
// Sequencer for the horizontal positions of the four pipe obstacles.
// On a start request it walks the initial-position ROM and loads every
// pipe's X, one pipe per cycle. On each frame tick it scrolls all four
// pipes left by SPEED pixels, one pipe per cycle, and wraps any pipe that
// would leave the screen back to the right by WRAP_SPAN pixels. Each wrap
// is reported so the gap-height generator can pick a new gap for that pipe.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_start        begins a (re)load from IDLE or HALT
//   i_frame_tick   one-cycle pulse per video frame
//   i_crash        one-cycle pulse, freezes scrolling
//   o_rom_addr     index into the initial-position ROM (0 outside LOAD)
//   i_rom_data     initial X returned by the ROM in the same cycle
//   o_pipe_x       packed X positions, pipe i at bits [10i+9:10i]
//   o_active       high while scrolling (RUN or UPDATE)
//   o_wrap_valid   one-cycle pulse, a pipe wrapped on the previous edge
//   o_wrap_idx     index of the wrapped pipe, valid with o_wrap_valid
//   o_overrun      sticky flag: a frame tick arrived while LOAD/UPDATE busy
// ----------------------------------------------------------------------------
module pipe_scroll_ctrl #(
    parameter int SPEED     = 2,
    parameter int WRAP_SPAN = 640
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_frame_tick,
    input  logic        i_crash,
    output logic [1:0]  o_rom_addr,
    input  logic [9:0]  i_rom_data,
    output logic [39:0] o_pipe_x,
    output logic        o_active,
    output logic        o_wrap_valid,
    output logic [1:0]  o_wrap_idx,
    output logic        o_overrun
);

    // Scroll step and the combined "jump right then step left" amount used
    // on a wrap. Both fit comfortably in 10 bits, and because a wrapping
    // pipe has x < SPEED the wrapped result never exceeds WRAP_SPAN - 1.
    localparam logic [9:0] L_SPEED    = 10'(SPEED);
    localparam logic [9:0] L_WRAP_ADD = 10'(WRAP_SPAN - SPEED);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        UPDATE,
        HALT
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [1:0]       r_idx;
    logic [3:0][9:0]  r_pipeX;
    logic             r_wrapValid;
    logic [1:0]       r_wrapIdx;
    logic             r_overrun;

    logic             w_inLoad;
    logic             w_inUpdate;
    logic             w_enterLoad;
    logic             w_lastIdx;
    logic [9:0]       w_curX;
    logic             w_wrap;
    logic [9:0]       w_nextX;

    // State register. Everything in this block falls back to IDLE on reset,
    // including a reset that lands in the middle of a load or an update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. LOAD and UPDATE each walk the four pipes using the
    // shared index counter and leave once pipe 3 has been handled. crash has
    // priority over frame_tick in RUN, and it aborts an UPDATE after the pipe
    // being processed in that cycle has been written.
    always_comb begin
        w_nextState = r_state;
        w_lastIdx   = (r_idx == 2'd3);
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                if (w_lastIdx) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (i_crash) begin
                    w_nextState = HALT;
                end else if (i_frame_tick) begin
                    w_nextState = UPDATE;
                end
            end
            UPDATE: begin
                if (i_crash) begin
                    w_nextState = HALT;
                end else if (w_lastIdx) begin
                    w_nextState = RUN;
                end
            end
            HALT: begin
                if (i_start) begin
                    w_nextState = LOAD;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Decoded state flags and the per-pipe scroll arithmetic for the pipe
    // currently selected by the index counter.
    always_comb begin
        w_inLoad    = (r_state == LOAD);
        w_inUpdate  = (r_state == UPDATE);
        w_enterLoad = (w_nextState == LOAD) && (r_state != LOAD);
        w_curX      = r_pipeX[r_idx];
        w_wrap      = (w_curX < L_SPEED);
        w_nextX     = w_wrap ? (w_curX + L_WRAP_ADD) : (w_curX - L_SPEED);
    end

    // Index counter shared by LOAD and UPDATE. It only counts inside those
    // two states and sits at zero everywhere else, so every walk starts at
    // pipe 0 even after an UPDATE was cut short by a crash.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx <= 2'd0;
        end else if (w_inLoad || w_inUpdate) begin
            r_idx <= r_idx + 2'd1;
        end else begin
            r_idx <= 2'd0;
        end
    end

    // Pipe position registers. LOAD copies the ROM word for the selected
    // pipe; UPDATE writes back the scrolled (or wrapped) position. In every
    // other state the positions simply hold, which is what freezes the
    // screen after a crash.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pipeX <= '0;
        end else if (w_inLoad) begin
            r_pipeX[r_idx] <= i_rom_data;
        end else if (w_inUpdate) begin
            r_pipeX[r_idx] <= w_nextX;
        end
    end

    // Wrap report. It is registered on the same edge that writes the wrapped
    // position, so the pulse appears in the following cycle alongside the
    // new X value and lasts exactly one cycle. The index is left holding its
    // last value between pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrapValid <= 1'b0;
            r_wrapIdx   <= 2'd0;
        end else begin
            r_wrapValid <= w_inUpdate && w_wrap;
            if (w_inUpdate && w_wrap) begin
                r_wrapIdx <= r_idx;
            end
        end
    end

    // Sticky overrun flag. A frame tick that arrives while the sequencer is
    // busy loading or updating is dropped and remembered here. Starting a
    // fresh load clears it; entering LOAD only happens from IDLE or HALT, so
    // the clear and set conditions can never coincide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overrun <= 1'b0;
        end else if (w_enterLoad) begin
            r_overrun <= 1'b0;
        end else if (i_frame_tick && (w_inLoad || w_inUpdate)) begin
            r_overrun <= 1'b1;
        end
    end

    // Output drive. The ROM address is only meaningful during LOAD and is
    // parked at zero otherwise so the ROM sees a quiet bus.
    assign o_rom_addr   = w_inLoad ? r_idx : 2'd0;
    assign o_pipe_x     = r_pipeX;
    assign o_active     = (r_state == RUN) || (r_state == UPDATE);
    assign o_wrap_valid = r_wrapValid;
    assign o_wrap_idx   = r_wrapIdx;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_pipe_scroll_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_scroll_ctrl
//
// Bench for pipe_scroll_ctrl. A small ROM with the positions 0/160/320/480
// feeds the load. Directed sequences exercise load, scrolling with wraps,
// overrun, crash in UPDATE, crash together with a frame tick, and reset in
// the middle of an update. Each expected wrap is queued when the frame tick
// is issued; an independent monitor pops the queue whenever the DUT raises
// wrap_valid and checks the wrapped pipe's index and new position.
// ----------------------------------------------------------------------------
module tb_pipe_scroll_ctrl;

    localparam int SPEED     = 2;
    localparam int WRAP_SPAN = 640;

    logic        clk;
    logic        reset;
    logic        start;
    logic        frameTick;
    logic        crash;
    logic [1:0]  romAddr;
    logic [9:0]  romData;
    logic [39:0] pipeX;
    logic        active;
    logic        wrapValid;
    logic [1:0]  wrapIdx;
    logic        overrun;

    typedef struct {
        logic [1:0] idx;
        logic [9:0] x;
    } wrap_t;

    wrap_t      sbQ[$];
    int         testsRun  = 0;
    int         failCount = 0;
    int         modelX[4];
    logic [9:0] romTable[4] = '{10'd0, 10'd160, 10'd320, 10'd480};

    pipe_scroll_ctrl #(
        .SPEED     (SPEED),
        .WRAP_SPAN (WRAP_SPAN)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_frame_tick (frameTick),
        .i_crash      (crash),
        .o_rom_addr   (romAddr),
        .i_rom_data   (romData),
        .o_pipe_x     (pipeX),
        .o_active     (active),
        .o_wrap_valid (wrapValid),
        .o_wrap_idx   (wrapIdx),
        .o_overrun    (overrun)
    );

    // Combinational initial-position ROM.
    assign romData = romTable[romAddr];

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Compare one value and keep the counters.
    task automatic checkOutput(input string name, input logic [39:0] actual,
                               input logic [39:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle worth of inputs, step past the edge, then release them.
    task automatic applyStimulus(input logic s, input logic ft, input logic cr);
        start     = s;
        frameTick = ft;
        crash     = cr;
        @(posedge clk);
        #1;
        start     = 1'b0;
        frameTick = 1'b0;
        crash     = 1'b0;
    endtask

    function automatic logic [39:0] packModel();
        logic [39:0] v;
        v = '0;
        for (int p = 0; p < 4; p++) begin
            v[p*10 +: 10] = 10'(modelX[p]);
        end
        return v;
    endfunction

    // Issue a frame tick in RUN and let the four UPDATE cycles run. The
    // reference positions advance here and every wrap is queued.
    // overrunAt >= 0 places an extra frame tick in that UPDATE cycle.
    task automatic runFrame(input int overrunAt);
        wrap_t w;
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 4; p++) begin
            if (modelX[p] < SPEED) begin
                modelX[p] = modelX[p] + WRAP_SPAN - SPEED;
                w.idx = 2'(p);
                w.x   = 10'(modelX[p]);
                sbQ.push_back(w);
            end else begin
                modelX[p] = modelX[p] - SPEED;
            end
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, (c == overrunAt), 1'b0);
        end
    endtask

    // Load from IDLE/HALT: start pulse followed by the four ROM cycles.
    task automatic doLoad();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        modelX = '{0, 160, 320, 480};
    endtask

    // Neighbouring pipes must stay 160 px apart modulo the wrap span.
    task automatic checkSpacing();
        int a;
        int b;
        for (int p = 0; p < 4; p++) begin
            a = int'(pipeX[p*10 +: 10]);
            b = int'(pipeX[((p + 1) % 4)*10 +: 10]);
            checkOutput($sformatf("spacing %0d-%0d", p, (p + 1) % 4),
                        40'((b - a + WRAP_SPAN) % WRAP_SPAN), 40'd160);
        end
    endtask

    // Wrap monitor: every wrap_valid cycle must match the next queued wrap.
    always @(negedge clk) begin
        wrap_t w;
        if (wrapValid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected wrap_valid", 40'(wrapIdx), 40'hFF);
            end else begin
                w = sbQ.pop_front();
                checkOutput("wrap_idx", 40'(wrapIdx), 40'(w.idx));
                checkOutput("wrapped pipe x", 40'(pipeX[w.idx*10 +: 10]), 40'(w.x));
            end
        end
    end

    initial begin
        wrap_t w;
        reset     = 1'b1;
        start     = 1'b0;
        frameTick = 1'b0;
        crash     = 1'b0;
        modelX    = '{0, 0, 0, 0};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset pipe_x", pipeX, 40'd0);
        checkOutput("reset rom_addr", 40'(romAddr), 40'd0);
        checkOutput("reset active", 40'(active), 40'd0);
        checkOutput("reset wrap_valid", 40'(wrapValid), 40'd0);
        checkOutput("reset wrap_idx", 40'(wrapIdx), 40'd0);
        checkOutput("reset overrun", 40'(overrun), 40'd0);

        $display("[TB] initial load");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("load rom_addr %0d", i), 40'(romAddr), 40'(i));
            checkOutput("active during load", 40'(active), 40'd0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        modelX = '{0, 160, 320, 480};
        checkOutput("loaded pipe_x", pipeX, {10'd480, 10'd320, 10'd160, 10'd0});
        checkOutput("active after load", 40'(active), 40'd1);
        checkOutput("rom_addr after load", 40'(romAddr), 40'd0);
        checkOutput("overrun after load", 40'(overrun), 40'd0);

        $display("[TB] first frame");
        runFrame(-1);
        checkOutput("frame1 pipe_x", pipeX, {10'd478, 10'd318, 10'd158, 10'd638});
        checkOutput("frame1 active", 40'(active), 40'd1);
        checkSpacing();

        $display("[TB] frames 2..80");
        for (int f = 2; f <= 80; f++) begin
            runFrame(-1);
            checkOutput($sformatf("frame%0d pipe_x", f), pipeX, packModel());
            checkSpacing();
        end
        checkOutput("frame80 pipe1", 40'(pipeX[19:10]), 40'd0);

        $display("[TB] frame 81");
        runFrame(-1);
        checkOutput("frame81 pipe_x", pipeX, {10'd318, 10'd158, 10'd638, 10'd478});
        checkSpacing();

        $display("[TB] overrun");
        runFrame(2);
        checkOutput("overrun set", 40'(overrun), 40'd1);
        checkOutput("frame82 pipe_x", pipeX, packModel());
        runFrame(-1);
        checkOutput("overrun sticky", 40'(overrun), 40'd1);
        checkOutput("frame83 pipe_x", pipeX, {10'd314, 10'd154, 10'd634, 10'd474});

        $display("[TB] crash in update cycle 1");
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("crash pipe_x", pipeX, {10'd314, 10'd154, 10'd632, 10'd472});
        checkOutput("crash active", 40'(active), 40'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("halt pipe_x frozen", pipeX, {10'd314, 10'd154, 10'd632, 10'd472});
        checkOutput("halt active", 40'(active), 40'd0);

        $display("[TB] reload from halt");
        doLoad();
        checkOutput("reload pipe_x", pipeX, {10'd480, 10'd320, 10'd160, 10'd0});
        checkOutput("reload active", 40'(active), 40'd1);
        checkOutput("overrun cleared by load", 40'(overrun), 40'd0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start ignored in run", 40'(active), 40'd1);
        checkOutput("rom_addr in run", 40'(romAddr), 40'd0);

        $display("[TB] crash with frame tick");
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("crash+tick active", 40'(active), 40'd0);
        checkOutput("crash+tick pipe_x", pipeX, {10'd480, 10'd320, 10'd160, 10'd0});
        checkOutput("crash+tick overrun", 40'(overrun), 40'd0);

        $display("[TB] reset during update");
        doLoad();
        applyStimulus(1'b0, 1'b1, 1'b0);
        w.idx = 2'd0;
        w.x   = 10'd638;
        sbQ.push_back(w);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("mid-update pipe0", 40'(pipeX[9:0]), 40'd638);
        checkOutput("mid-update overrun", 40'(overrun), 40'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("post-reset pipe_x", pipeX, 40'd0);
        checkOutput("post-reset active", 40'(active), 40'd0);
        checkOutput("post-reset overrun", 40'(overrun), 40'd0);
        checkOutput("post-reset wrap_valid", 40'(wrapValid), 40'd0);
        checkOutput("post-reset rom_addr", 40'(romAddr), 40'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle after reset pipe_x", pipeX, 40'd0);

        checkOutput("wraps outstanding", 40'(sbQ.size()), 40'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
